alu_pipe_cc: RTL and testbench
==============================

Name: alu_pipe_cc

Overview:
- Parametrised, pipelined successor to the combinational 64-bit add/sub blocks in the ALU directory.
- Performs the Y86-64 OPq set: ADD, SUB, AND, XOR, at configurable width and latency.
- Valid/ready handshake with backpressure on both sides.
- Holds the architectural condition-code register (ZF, SF, OF), updated as results retire.
- Sits between the decode/execute operand latches and writeback; the branch/cmov logic reads the CC outputs.

Parameters:
- WIDTH, 64, operand/result width in bits; legal range 8..64.
- LATENCY, 2, pipeline stages from accept to result-valid; legal range 1..4.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_op  in  2  operation: 0=ADD, 1=SUB, 2=AND, 3=XOR.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_set_cc  in  1  this op updates CC when it retires.
- flush  in  1  discard all in-flight ops.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  result.
- out_zf, out_sf, out_of  out  1 each  flags of this result.
- cc_zf, cc_sf, cc_of  out  1 each  architectural CC register.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All stage valid bits cleared; out_valid=0.
  - out_result=0; out_zf=0, out_sf=0, out_of=0.
  - cc_zf=1, cc_sf=0, cc_of=0.
  - Reset mid-operation drops every in-flight op with no CC update.
  - in_ready is 0 while rst=1.
- Arithmetic:
  - ADD: A+B mod 2^WIDTH. SUB: A-B mod 2^WIDTH, computed as A + ~B + 1.
  - AND: A&B. XOR: A^B.
  - ZF = (result==0). SF = result[WIDTH-1].
  - OF for ADD: A and B have the same sign and the result sign differs.
  - OF for SUB: A and B have different signs and the result sign differs from A.
  - OF is 0 for AND and XOR.
  - Carry-out is not exported.
- Pipeline:
  - LATENCY register stages, each holding valid, op, set_cc, partial/full result and flags.
  - Computation may be split across stages freely; only the final-stage outputs are specified.
  - Global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv && !flush && !rst.
  - Beat accepted when in_valid && in_ready.
  - When adv=1, every stage shifts forward by one and stage 0 loads the accepted beat (or a bubble).
  - When adv=0, all stages hold, and out_* are stable while out_valid=1 && out_ready=0.
  - An accepted beat appears at out_valid exactly LATENCY cycles later if there has been no stall; each stall cycle adds one.
  - Bubbles are not collapsed. Throughput is 1 beat/cycle with out_ready held high.
- CC update:
  - On a retire handshake (out_valid && out_ready) where the retiring op had set_cc=1, the CC register loads that beat's flags at the clock edge.
  - CC is visible the cycle after retirement. Otherwise CC holds.
- flush:
  - Clears all stage valid bits at the edge, including the final stage. This overrides a same-cycle retire handshake: the CC update is suppressed and the consumer must ignore that beat.
  - in_ready=0 during flush, so no beat is accepted.
  - flush does not modify CC.
- rst has priority over flush; flush has priority over advance.

Decomposition:
- Shared package alu_pkg:
  - op encodings ALU_ADD=2'd0, ALU_SUB=2'd1, ALU_AND=2'd2, ALU_XOR=2'd3.
  - CC reset constants.
  - a packed flags typedef {zf, sf, of}.
- Sub-module alu_core:
  - combinational, WIDTH-parametrised; op, a, b -> result, zf, sf, of.
  - Built from the existing ripple add path with B inversion for SUB.
  - alu_pipe_cc instantiates alu_core in stage 0 and carries its outputs through the remaining stages.

Test Plan:
- WIDTH=64, LATENCY=2, out_ready=1: SUB A=0x7FFF_FFFF_FFFF_FFFF, B=0x8000_0000_0000_0000, set_cc=1 -> out_valid 2 cycles after accept, result 0xFFFF_FFFF_FFFF_FFFF, ZF=0, SF=1, OF=1; CC={0,1,1} the following cycle.
- SUB A=0x8000_0000_0000_0000, B=0x7FFF_FFFF_FFFF_FFFF -> result 0x0000_0000_0000_0001, SF=0, OF=1. SUB A=5, B=14 -> 0xFFFF_FFFF_FFFF_FFF7, SF=1, OF=0. SUB A=B=0x8000_0000_0000_0000 -> 0, ZF=1, OF=0.
- ADD 0x7FFF_FFFF_FFFF_FFFF + 1 with set_cc=0 -> result 0x8000_0000_0000_0000, OF=1, SF=1; CC unchanged. XOR A=B=0xDEAD -> 0, ZF=1, OF=0.
- Backpressure: stream 4 back-to-back beats, out_ready low for 3 cycles mid-stream -> in_ready low during the stall, out_* stable, all 4 results retire in order, none lost or duplicated.
- Flush with 2 ops in flight (set_cc=1) -> neither retires, CC unchanged, next accepted op retires after LATENCY cycles.
- rst asserted mid-stream -> out_valid=0 and CC={1,0,0} after the edge. Repeat directed cases at WIDTH=8, LATENCY=1 and LATENCY=4: 8'h7F - 8'h80 -> 8'hFF, OF=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined Y86-64 OPq ALU: op encodings, flag
// bundle and the architectural condition-code reset value.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_op_e;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } alu_flags_t;

    // After reset the machine looks as if the last result was zero.
    localparam alu_flags_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/alu_core.sv
// Combinational OPq datapath: ripple-carry add with B inversion for SUB,
// plus bitwise AND/XOR, producing the result and its ZF/SF/OF flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             sf,
    output logic             of
);

    logic             sub;
    logic             arith;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] carry;

    assign sub      = (op == ALU_SUB);
    assign arith    = (op == ALU_ADD) || sub;
    assign b_eff    = sub ? ~b : b;
    assign carry[0] = sub;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_ripple
            assign sum[gi] = a[gi] ^ b_eff[gi] ^ carry[gi];
            // The carry out of the top bit is never needed, so the chain stops one short.
            if (gi < WIDTH - 1) begin : g_carry
                assign carry[gi+1] = (a[gi] & b_eff[gi]) | (carry[gi] & (a[gi] ^ b_eff[gi]));
            end
        end
    endgenerate

    always_comb begin
        result = sum;
        case (alu_op_e'(op))
            ALU_AND: result = a & b;
            ALU_XOR: result = a ^ b;
            default: result = sum;
        endcase
    end

    // With B already inverted for SUB, both overflow rules reduce to: the
    // adder inputs agree in sign and the sum's sign disagrees with them.
    assign of = arith && (a[WIDTH-1] == b_eff[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
    assign zf = (result == '0);
    assign sf = result[WIDTH-1];

endmodule

// File: rtl/alu_pipe_cc.sv
// Pipelined OPq ALU with valid/ready handshake, flush, and the architectural
// condition-code register that is loaded as flag-setting results retire.
module alu_pipe_cc
    import alu_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_set_cc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zf,
    output logic             out_sf,
    output logic             out_of,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);

    logic [WIDTH-1:0] core_result;
    logic             core_zf;
    logic             core_sf;
    logic             core_of;
    alu_flags_t       core_flags;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op     (in_op),
        .a      (in_a),
        .b      (in_b),
        .result (core_result),
        .zf     (core_zf),
        .sf     (core_sf),
        .of     (core_of)
    );

    assign core_flags = '{zf: core_zf, sf: core_sf, of: core_of};

    logic             valid_reg  [LATENCY];
    logic             set_cc_reg [LATENCY];
    logic [WIDTH-1:0] result_reg [LATENCY];
    alu_flags_t       flags_reg  [LATENCY];
    alu_flags_t       cc_reg;

    logic adv;
    logic retire;

    assign adv      = !valid_reg[LATENCY-1] || out_ready;
    assign in_ready = adv && !flush && !rst;
    // A flush in the same cycle cancels the handshake, so the beat never counts as retired.
    assign retire   = valid_reg[LATENCY-1] && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                valid_reg[i]  <= 1'b0;
                set_cc_reg[i] <= 1'b0;
                result_reg[i] <= '0;
                flags_reg[i]  <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < LATENCY; i++) begin
                valid_reg[i] <= 1'b0;
            end
        end else if (adv) begin
            valid_reg[0]  <= in_valid && in_ready;
            set_cc_reg[0] <= in_set_cc;
            result_reg[0] <= core_result;
            flags_reg[0]  <= core_flags;
            for (int i = 1; i < LATENCY; i++) begin
                valid_reg[i]  <= valid_reg[i-1];
                set_cc_reg[i] <= set_cc_reg[i-1];
                result_reg[i] <= result_reg[i-1];
                flags_reg[i]  <= flags_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_reg <= CC_RESET;
        end else if (retire && set_cc_reg[LATENCY-1]) begin
            cc_reg <= flags_reg[LATENCY-1];
        end
    end

    assign out_valid  = valid_reg[LATENCY-1];
    assign out_result = result_reg[LATENCY-1];
    assign out_zf     = flags_reg[LATENCY-1].zf;
    assign out_sf     = flags_reg[LATENCY-1].sf;
    assign out_of     = flags_reg[LATENCY-1].of;
    assign cc_zf      = cc_reg.zf;
    assign cc_sf      = cc_reg.sf;
    assign cc_of      = cc_reg.of;

endmodule

// File: tb/tb_alu_pipe_cc.sv
// Scoreboard bench: 64-bit/latency-2 instance under random traffic plus
// directed 8-bit checks at latency 1 and 4.
module tb_alu_pipe_cc;
    import alu_pkg::*;

    localparam int W = 64;
    localparam int L = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, in_valid, in_set_cc, flush, out_ready;
    logic [1:0]    in_op;
    logic [W-1:0]  in_a, in_b;
    logic          in_ready, out_valid, out_zf, out_sf, out_of, cc_zf, cc_sf, cc_of;
    logic [W-1:0]  out_result;

    alu_pipe_cc #(.WIDTH(W), .LATENCY(L)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_set_cc(in_set_cc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zf(out_zf), .out_sf(out_sf), .out_of(out_of),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
    );

    // Two narrow instances sharing one stimulus.
    logic       s_valid, s_set_cc, s_flush, s_out_ready;
    logic [1:0] s_op;
    logic [7:0] s_a, s_b;
    logic       s1_in_ready, s1_out_valid, s1_zf, s1_sf, s1_of, s1_cz, s1_cs, s1_co;
    logic       s4_in_ready, s4_out_valid, s4_zf, s4_sf, s4_of, s4_cz, s4_cs, s4_co;
    logic [7:0] s1_res, s4_res;

    alu_pipe_cc #(.WIDTH(8), .LATENCY(1)) dut_w8l1 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s1_in_ready), .in_op(s_op),
        .in_a(s_a), .in_b(s_b), .in_set_cc(s_set_cc), .flush(s_flush),
        .out_valid(s1_out_valid), .out_ready(s_out_ready), .out_result(s1_res),
        .out_zf(s1_zf), .out_sf(s1_sf), .out_of(s1_of),
        .cc_zf(s1_cz), .cc_sf(s1_cs), .cc_of(s1_co)
    );

    alu_pipe_cc #(.WIDTH(8), .LATENCY(4)) dut_w8l4 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s4_in_ready), .in_op(s_op),
        .in_a(s_a), .in_b(s_b), .in_set_cc(s_set_cc), .flush(s_flush),
        .out_valid(s4_out_valid), .out_ready(s_out_ready), .out_result(s4_res),
        .out_zf(s4_zf), .out_sf(s4_sf), .out_of(s4_of),
        .cc_zf(s4_cz), .cc_sf(s4_cs), .cc_of(s4_co)
    );

    typedef struct {
        logic [63:0] res;
        logic        zf, sf, of, set_cc;
        int          acc, stl;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0, n_bad = 0;
    int          cyc = 0, stall_cnt = 0, n_ret = 0;
    int          ready_mode = 0, stall_req = 0;
    logic [2:0]  model_cc = 3'b100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain modular arithmetic and sign rules at width w.
    function automatic exp_t model(input int w, input logic [1:0] op, input logic [63:0] a_in,
                                   input logic [63:0] b_in, input logic sc);
        exp_t        e;
        logic [63:0] mask, a, b;
        logic        sa, sb, sr;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        a = a_in & mask;
        b = b_in & mask;
        case (op)
            2'd0:    e.res = (a + b) & mask;
            2'd1:    e.res = (a - b) & mask;
            2'd2:    e.res = a & b;
            default: e.res = a ^ b;
        endcase
        sa = a[w-1];
        sb = b[w-1];
        sr = e.res[w-1];
        e.zf = (e.res == 64'd0);
        e.sf = sr;
        e.of = (op == 2'd0) ? (sa == sb && sr != sa) :
               (op == 2'd1) ? (sa != sb && sr != sa) : 1'b0;
        e.set_cc = sc;
        e.acc = 0;
        e.stl = 0;
        return e;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'h7FFF_FFFF_FFFF_FFFF;
            1:       return 64'h8000_0000_0000_0000;
            2:       return 64'd0;
            3:       return {64{1'b1}};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Consumer-side ready pattern, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (stall_req > 0) begin
            out_ready = 1'b0;
            stall_req--;
        end else if (ready_mode == 1) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = 1'b1;
        end
    end

    // Monitor: compares every retire against the scoreboard, and checks
    // handshake rules, stall stability and CC every cycle.
    initial begin
        exp_t        e;
        bit          armed = 0, rst_prev = 0, flush_prev = 0, hold_v = 0;
        logic [63:0] hold_res;
        logic [2:0]  hold_fl;
        forever begin
            @(negedge clk);
            if (armed) begin
                if (rst_prev) begin
                    chk("reset out_valid", out_valid, 0);
                    chk("reset out_result", out_result, 0);
                    chk("reset out flags", {out_zf, out_sf, out_of}, 0);
                end else if (flush_prev) begin
                    chk("flush out_valid", out_valid, 0);
                end
                if (hold_v) begin
                    chk("stall out_valid", out_valid, 1);
                    chk("stall out_result", out_result, hold_res);
                    chk("stall out flags", {out_zf, out_sf, out_of}, hold_fl);
                end
                chk("cc", {cc_zf, cc_sf, cc_of}, model_cc);
                chk("in_ready", in_ready, (!out_valid || out_ready) && !flush && !rst);
                hold_v = 0;
                if (rst) begin
                    q.delete();
                    model_cc = 3'b100;
                end else if (flush) begin
                    q.delete();
                end else if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("spurious retire", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("result", out_result, e.res);
                        chk("flags", {out_zf, out_sf, out_of}, {e.zf, e.sf, e.of});
                        chk("latency", cyc - e.acc, L + stall_cnt - e.stl);
                        if (e.set_cc) model_cc = {e.zf, e.sf, e.of};
                        n_ret++;
                        $display("retire %0d: result=0x%h zf=%b sf=%b of=%b set_cc=%b",
                                 n_ret, out_result, out_zf, out_sf, out_of, e.set_cc);
                    end
                end else if (out_valid) begin
                    hold_v   = 1;
                    hold_res = out_result;
                    hold_fl  = {out_zf, out_sf, out_of};
                    stall_cnt++;
                end
            end
            if (rst) armed = 1;
            rst_prev   = rst;
            flush_prev = flush;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input logic sc);
        exp_t e;
        int   t;
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_set_cc = sc;
        for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (t == 200) begin
            chk("accept timeout", 0, 1);
        end else begin
            e = model(W, op, a, b, sc);
            e.acc = cyc;
            e.stl = stall_cnt;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic small_case(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   l1, l4;
        e = model(8, op, {56'd0, a}, {56'd0, b}, 1'b1);
        s_valid = 1'b1;
        s_op    = op;
        s_a     = a;
        s_b     = b;
        @(negedge clk);
        chk("w8 in_ready", {s1_in_ready, s4_in_ready}, 2'b11);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        l1 = -1;
        l4 = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (s1_out_valid && l1 < 0) begin
                l1 = k;
                chk("w8l1 result", s1_res, e.res);
                chk("w8l1 flags", {s1_zf, s1_sf, s1_of}, {e.zf, e.sf, e.of});
            end
            if (s4_out_valid && l4 < 0) begin
                l4 = k;
                chk("w8l4 result", s4_res, e.res);
                chk("w8l4 flags", {s4_zf, s4_sf, s4_of}, {e.zf, e.sf, e.of});
            end
        end
        chk("w8l1 latency", l1, 1);
        chk("w8l4 latency", l4, 4);
        chk("w8l1 cc", {s1_cz, s1_cs, s1_co}, {e.zf, e.sf, e.of});
        chk("w8l4 cc", {s4_cz, s4_cs, s4_co}, {e.zf, e.sf, e.of});
        $display("w8 case op=%0d a=0x%h b=0x%h: l1=0x%h l4=0x%h", op, a, b, s1_res, s4_res);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_set_cc = 1'b0;
        in_op = 2'd0; in_a = '0; in_b = '0; out_ready = 1'b1;
        s_valid = 1'b0; s_set_cc = 1'b1; s_flush = 1'b0; s_out_ready = 1'b1;
        s_op = 2'd0; s_a = '0; s_b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        send(ALU_SUB, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1);
        idle(4);
        send(ALU_SUB, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        send(ALU_SUB, 64'd5, 64'd14, 1'b1);
        send(ALU_SUB, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
        idle(4);
        send(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        send(ALU_XOR, 64'hDEAD, 64'hDEAD, 1'b0);
        idle(4);

        // Backpressure in the middle of four back-to-back beats.
        send(ALU_ADD, 64'd10, 64'd20, 1'b1);
        send(ALU_SUB, 64'd7, 64'd9, 1'b1);
        stall_req = 3;
        send(ALU_AND, 64'hF0F0, 64'h0FF0, 1'b1);
        send(ALU_ADD, 64'd1, 64'd2, 1'b1);
        idle(8);

        // Two flag-setting ops in flight are discarded by flush.
        send(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        send(ALU_SUB, 64'd0, 64'd0, 1'b1);
        pulse_flush();
        send(ALU_XOR, 64'h1234, 64'h00FF, 1'b1);
        idle(5);

        ready_mode = 1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 39))
                0:       pulse_flush();
                1:       idle($urandom_range(1, 3));
                default: send(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)));
            endcase
        end
        ready_mode = 0;
        idle(6);

        // Reset with beats still in flight.
        send(ALU_SUB, 64'd1, 64'd2, 1'b1);
        send(ALU_ADD, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
        send(ALU_SUB, 64'd3, 64'd3, 1'b0);
        pulse_rst();
        send(ALU_AND, {64{1'b1}}, 64'h8000_0000_0000_0001, 1'b1);

        for (int t = 0; t < 100 && q.size() > 0; t++) @(posedge clk);
        chk("drain", q.size(), 0);
        idle(2);

        small_case(ALU_SUB, 8'h7F, 8'h80);
        small_case(ALU_ADD, 8'h7F, 8'h01);
        small_case(ALU_SUB, 8'h80, 8'h7F);
        small_case(ALU_XOR, 8'h5A, 8'h5A);
        small_case(ALU_AND, 8'hC3, 8'h81);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global timeout: bench still running at t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
